ps2_cmd_ctrl: RTL and testbench

PS2_CMD_CTRL -- requirements
Module: ps2_cmd_ctrl

---
 rtl/ps2_cmd_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_cmd_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host command controller: resets the device, waits for BAT, then serves LED and raw command requests.
// Latency: bus_enable one cycle after grant/ready; acks and scan codes registered one cycle after bus_rx_complete.
// Backpressure: waits on bus_tx_ready before each byte; requests are only sampled in IDLE. Macro PS2_CTRL_RETRY_EN enables resend on 0xFE/tx fail.
module ps2_cmd_ctrl #(
    parameter int TIMEOUT   = 20000,
    parameter int MAX_RETRY = 3
) (
    input  logic       clock_quarter,
    input  logic       reset_n,
    output logic       bus_enable,
    output logic [7:0] bus_tx_data,
    input  logic       bus_tx_ready,
    input  logic       bus_tx_faild,
    input  logic       bus_rx_complete,
    input  logic [7:0] bus_rx_data,
    input  logic       led_req,
    input  logic [2:0] led_mask,
    output logic       led_ack,
    input  logic       cmd_req,
    input  logic [7:0] cmd_byte,
    output logic       cmd_ack,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       init_done,
    output logic       error
);

    localparam logic [7:0] BYTE_RESET  = 8'hFF;
    localparam logic [7:0] BYTE_SETLED = 8'hED;
    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;
    localparam logic [7:0] BYTE_BAT_OK = 8'hAA;
    localparam logic [7:0] BYTE_BAT_NG = 8'hFC;

    localparam int              TW       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   TMO_SAT  = TW'(TIMEOUT);

    typedef enum logic [3:0] {
        RST_TX, RST_ACK, BAT_WAIT, IDLE, TX1, ACK1, TX2, ACK2, FAIL
    } state_t;

    state_t          state;
    logic            started;     // one settling cycle after reset before the first send
    logic [TW-1:0]   timer;
    logic            is_led;      // current transaction is an LED update
    logic [2:0]      mask_q;      // led_mask captured at grant

    logic            rx_ack;
    logic            rx_resend;
    logic            in_ack;
    logic            nack;
    logic            timer_hit;
    logic            retry_ok;

    // Decode the device reply and the current wait condition
    always_comb begin
        rx_ack    = bus_rx_complete && (bus_rx_data == BYTE_ACK);
        rx_resend = bus_rx_complete && (bus_rx_data == BYTE_RESEND);
        in_ack    = (state == RST_ACK) || (state == ACK1) || (state == ACK2);
        nack      = in_ack && (rx_resend || bus_tx_faild);
        timer_hit = (in_ack || (state == BAT_WAIT)) && (timer == TMO_LAST);
    end

`ifdef PS2_CTRL_RETRY_EN
    localparam int            RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    logic [RW-1:0] retry_cnt;

    assign retry_ok = (retry_cnt != RETRY_LIM);

    // Count resends of the current byte; a clean 0xFA starts the next byte fresh
    always_ff @(posedge clock_quarter or negedge reset_n) begin
        if (!reset_n) begin
            retry_cnt <= '0;
        end else if (nack) begin
            if (retry_ok) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
        end else if (in_ack && rx_ack) begin
            retry_cnt <= '0;
        end
    end
`else
    logic unused_retry_cfg;

    assign unused_retry_cfg = (MAX_RETRY > 0);
    assign retry_ok         = 1'b0;
`endif

    // Main controller: sequencing, timeout, and all registered outputs
    always_ff @(posedge clock_quarter or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RST_TX;
            started     <= 1'b0;
            timer       <= '0;
            is_led      <= 1'b0;
            mask_q      <= '0;
            bus_enable  <= 1'b0;
            bus_tx_data <= '0;
            led_ack     <= 1'b0;
            cmd_ack     <= 1'b0;
            scan_valid  <= 1'b0;
            scan_code   <= '0;
            init_done   <= 1'b0;
            error       <= 1'b0;
        end else begin
            bus_enable <= 1'b0;
            led_ack    <= 1'b0;
            cmd_ack    <= 1'b0;
            scan_valid <= 1'b0;

            if (timer != TMO_SAT) begin
                timer <= timer + 1'b1;
            end

            case (state)
                RST_TX: begin
                    bus_tx_data <= BYTE_RESET;
                    started     <= 1'b1;
                    if (started && bus_tx_ready) begin
                        bus_enable <= 1'b1;
                        timer      <= '0;
                        state      <= RST_ACK;
                    end
                end

                TX1, TX2: begin
                    if (bus_tx_ready) begin
                        bus_enable <= 1'b1;
                        timer      <= '0;
                        state      <= (state == TX1) ? ACK1 : ACK2;
                    end
                end

                RST_ACK, ACK1, ACK2: begin
                    if (nack) begin
                        // Resend the held byte from the matching TX state, or give up
                        if (retry_ok) begin
                            state <= (state == RST_ACK) ? RST_TX :
                                     (state == ACK1)    ? TX1    : TX2;
                        end else begin
                            state     <= FAIL;
                            error     <= 1'b1;
                            init_done <= 1'b0;
                        end
                    end else if (rx_ack) begin
                        if (state == RST_ACK) begin
                            timer <= '0;
                            state <= BAT_WAIT;
                        end else if (state == ACK1 && is_led) begin
                            bus_tx_data <= {5'b0, mask_q};
                            state       <= TX2;
                        end else if (state == ACK1) begin
                            cmd_ack <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            led_ack <= 1'b1;
                            state   <= IDLE;
                        end
                    end else begin
                        // Unsolicited bytes pass through while we keep waiting
                        if (bus_rx_complete) begin
                            scan_valid <= 1'b1;
                            scan_code  <= bus_rx_data;
                        end
                        if (timer_hit) begin
                            state     <= FAIL;
                            error     <= 1'b1;
                            init_done <= 1'b0;
                        end
                    end
                end

                BAT_WAIT: begin
                    if (bus_rx_complete && bus_rx_data == BYTE_BAT_OK) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end else if (bus_rx_complete && bus_rx_data == BYTE_BAT_NG) begin
                        state <= FAIL;
                        error <= 1'b1;
                    end else begin
                        if (bus_rx_complete) begin
                            scan_valid <= 1'b1;
                            scan_code  <= bus_rx_data;
                        end
                        if (timer_hit) begin
                            state <= FAIL;
                            error <= 1'b1;
                        end
                    end
                end

                IDLE: begin
                    // Every received byte is forwarded, even in the cycle a request is granted
                    if (bus_rx_complete) begin
                        scan_valid <= 1'b1;
                        scan_code  <= bus_rx_data;
                    end
                    if (led_req) begin
                        is_led      <= 1'b1;
                        mask_q      <= led_mask;
                        bus_tx_data <= BYTE_SETLED;
                        state       <= TX1;
                    end else if (cmd_req) begin
                        is_led      <= 1'b0;
                        bus_tx_data <= cmd_byte;
                        state       <= TX1;
                    end
                end

                FAIL: begin
                    error     <= 1'b1;
                    init_done <= 1'b0;
                end

                default: begin
                    state     <= FAIL;
                    error     <= 1'b1;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Bench for ps2_cmd_ctrl: a scripted device replies to each sent byte.
// Expected output events are queued when stimulus is driven and matched as the DUT emits them.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_ps2_cmd_ctrl;

    localparam int TMO = 200;
    localparam int MR  = 3;

    localparam logic [7:0] K_TX   = 8'h01;
    localparam logic [7:0] K_LED  = 8'h02;
    localparam logic [7:0] K_CMD  = 8'h03;
    localparam logic [7:0] K_SCAN = 8'h04;

    logic       clock_quarter = 1'b0;
    logic       reset_n       = 1'b0;
    logic       bus_enable;
    logic [7:0] bus_tx_data;
    logic       bus_tx_ready    = 1'b1;
    logic       bus_tx_faild    = 1'b0;
    logic       bus_rx_complete = 1'b0;
    logic [7:0] bus_rx_data     = 8'h00;
    logic       led_req  = 1'b0;
    logic [2:0] led_mask = 3'b000;
    logic       led_ack;
    logic       cmd_req  = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       cmd_ack;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       init_done;
    logic       error;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];

    ps2_cmd_ctrl #(.TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
        .clock_quarter   (clock_quarter),
        .reset_n         (reset_n),
        .bus_enable      (bus_enable),
        .bus_tx_data     (bus_tx_data),
        .bus_tx_ready    (bus_tx_ready),
        .bus_tx_faild    (bus_tx_faild),
        .bus_rx_complete (bus_rx_complete),
        .bus_rx_data     (bus_rx_data),
        .led_req         (led_req),
        .led_mask        (led_mask),
        .led_ack         (led_ack),
        .cmd_req         (cmd_req),
        .cmd_byte        (cmd_byte),
        .cmd_ack         (cmd_ack),
        .scan_valid      (scan_valid),
        .scan_code       (scan_code),
        .init_done       (init_done),
        .error           (error)
    );

    always #5 clock_quarter = ~clock_quarter;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic pop_cmp(input string tag, input logic [15:0] got);
        logic [15:0] e;
        if (exp_q.size() == 0) e = 16'hDEAD;
        else                   e = exp_q.pop_front();
        check_val(tag, {16'h0, got}, {16'h0, e});
    endtask

    function automatic logic [21:0] all_outs();
        return {bus_enable, bus_tx_data, led_ack, cmd_ack, scan_valid, scan_code, init_done, error};
    endfunction

    // Output monitor: every emitted event must match the head of the expectation queue
    always @(negedge clock_quarter) begin
        if (bus_enable) pop_cmp("tx_byte", {K_TX, bus_tx_data});
        if (led_ack)    pop_cmp("led_ack", {K_LED, 8'h00});
        if (cmd_ack)    pop_cmp("cmd_ack", {K_CMD, 8'h00});
        if (scan_valid) pop_cmp("scan",    {K_SCAN, scan_code});
        if (led_ack || cmd_ack) check_val("ack_excl", {31'h0, led_ack & cmd_ack}, 32'h0);
    end

    task automatic wait_enable();
        int n = 0;
        @(negedge clock_quarter);
        while (!bus_enable && n < 500) begin
            @(negedge clock_quarter);
            n++;
        end
        if (!bus_enable) check_val("enable_timeout", {31'h0, bus_enable}, 32'h1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus_rx_data     = b;
        bus_rx_complete = 1'b1;
        @(negedge clock_quarter);
        bus_rx_complete = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clock_quarter);
    endtask

    // Reset, device answers 0xFA then 0xAA, controller reaches IDLE
    task automatic do_init();
        reset_n = 1'b0;
        gap(3);
        check_val("reset_outs", {10'h0, all_outs()}, 32'h0);
        exp_q.push_back({K_TX, 8'hFF});
        reset_n = 1'b1;
        @(negedge clock_quarter);
        check_val("enable_early", {31'h0, bus_enable}, 32'h0);
        wait_enable();
        gap(2);
        send_rx(8'hFA);
        gap(2);
        check_val("init_before_bat", {31'h0, init_done}, 32'h0);
        send_rx(8'hAA);
        gap(2);
        check_val("init_done", {31'h0, init_done}, 32'h1);
        check_val("error_clear", {31'h0, error}, 32'h0);
        check_val("init_q_empty", exp_q.size(), 32'h0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_init();

        // LED update with mask 101; mask changes after grant must not leak in
        exp_q.push_back({K_TX, 8'hED});
        exp_q.push_back({K_TX, 8'h05});
        exp_q.push_back({K_LED, 8'h00});
        led_mask = 3'b101;
        led_req  = 1'b1;
        wait_enable();
        led_req  = 1'b0;
        led_mask = 3'b010;
        gap(2);
        send_rx(8'hFA);
        wait_enable();
        gap(2);
        send_rx(8'hFA);
        gap(3);
        check_val("led_q_empty", exp_q.size(), 32'h0);

        // LED and command together: LED wins, command follows
        exp_q.push_back({K_TX, 8'hED});
        exp_q.push_back({K_TX, 8'h03});
        exp_q.push_back({K_LED, 8'h00});
        exp_q.push_back({K_TX, 8'hF4});
        exp_q.push_back({K_CMD, 8'h00});
        led_mask = 3'b011;
        cmd_byte = 8'hF4;
        led_req  = 1'b1;
        cmd_req  = 1'b1;
        wait_enable();
        led_req = 1'b0;
        gap(2);
        send_rx(8'hFA);
        wait_enable();
        gap(2);
        send_rx(8'hFA);
        wait_enable();
        cmd_req  = 1'b0;
        cmd_byte = 8'h00;
        gap(2);
        send_rx(8'hFA);
        gap(3);
        check_val("prio_q_empty", exp_q.size(), 32'h0);

        // Back-to-back scan codes in IDLE
        exp_q.push_back({K_SCAN, 8'h1C});
        exp_q.push_back({K_SCAN, 8'hF0});
        send_rx(8'h1C);
        send_rx(8'hF0);
        gap(3);
        check_val("scan_q_empty", exp_q.size(), 32'h0);

        // Unrelated byte while awaiting an ack is forwarded, then the ack completes
        exp_q.push_back({K_TX, 8'hF2});
        cmd_byte = 8'hF2;
        cmd_req  = 1'b1;
        wait_enable();
        cmd_req = 1'b0;
        gap(2);
        exp_q.push_back({K_SCAN, 8'h55});
        send_rx(8'h55);
        gap(2);
        exp_q.push_back({K_CMD, 8'h00});
        send_rx(8'hFA);
        gap(3);
        check_val("mid_q_empty", exp_q.size(), 32'h0);

`ifdef PS2_CTRL_RETRY_EN
        // Two resend requests then an ack: three sends of the same byte
        cmd_byte = 8'hF4;
        cmd_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({K_TX, 8'hF4});
            wait_enable();
            cmd_req = 1'b0;
            gap(2);
            if (i < 2) send_rx(8'hFE);
            else begin
                exp_q.push_back({K_CMD, 8'h00});
                send_rx(8'hFA);
            end
        end
        gap(3);
        check_val("retry_q_empty", exp_q.size(), 32'h0);
        check_val("retry_no_err", {31'h0, error}, 32'h0);

        // Resend requested on every attempt: gives up after MAX_RETRY resends
        cmd_byte = 8'hF5;
        cmd_req  = 1'b1;
        for (int i = 0; i <= MR; i++) begin
            exp_q.push_back({K_TX, 8'hF5});
            wait_enable();
            cmd_req = 1'b0;
            gap(2);
            if (i < MR) check_val("retry_err_early", {31'h0, error}, 32'h0);
            send_rx(8'hFE);
        end
        gap(2);
        check_val("retry_exhaust_err", {31'h0, error}, 32'h1);
        check_val("retry_exhaust_init", {31'h0, init_done}, 32'h0);
`else
        // Resend request without retry support is fatal
        exp_q.push_back({K_TX, 8'hF4});
        cmd_byte = 8'hF4;
        cmd_req  = 1'b1;
        wait_enable();
        cmd_req = 1'b0;
        gap(2);
        send_rx(8'hFE);
        gap(2);
        check_val("nack_err", {31'h0, error}, 32'h1);
        check_val("nack_init", {31'h0, init_done}, 32'h0);
`endif
        // Requests are ignored once failed
        cmd_req = 1'b1;
        led_req = 1'b1;
        gap(10);
        cmd_req = 1'b0;
        led_req = 1'b0;
        check_val("fail_sticky", {31'h0, error}, 32'h1);
        check_val("fail_q_empty", exp_q.size(), 32'h0);
        do_init();

        // Silent device after 0xED: error exactly TMO cycles after entering ACK1
        exp_q.push_back({K_TX, 8'hED});
        led_mask = 3'b001;
        led_req  = 1'b1;
        wait_enable();
        led_req = 1'b0;
        gap(TMO - 1);
        check_val("tmo_not_yet", {31'h0, error}, 32'h0);
        gap(1);
        check_val("tmo_err", {31'h0, error}, 32'h1);
        do_init();

        // Reset while the second LED byte is waiting to go out
        exp_q.push_back({K_TX, 8'hED});
        led_mask = 3'b111;
        led_req  = 1'b1;
        wait_enable();
        led_req      = 1'b0;
        bus_tx_ready = 1'b0;
        gap(2);
        send_rx(8'hFA);
        gap(3);
        check_val("tx2_data", {24'h0, bus_tx_data}, 32'h07);
        check_val("tx2_held", {31'h0, bus_enable}, 32'h0);
        #2 reset_n = 1'b0;
        #1 check_val("async_reset_outs", {10'h0, all_outs()}, 32'h0);
        bus_tx_ready = 1'b1;
        do_init();

        check_val("final_q_empty", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
